lru_burst_sched: RTL

- Multi-cycle scheduler that shares one resource (bus or port) between REQ_NUM requesters.
- Uses the team's least-recently-granted policy: the winner moves to lowest priority.
- Unlike the single-cycle loop arbiter, a winner keeps the grant across a burst. The burst ends when the winner signals last, drops req, or hits a hold-cycle limit.
- All outputs are registered. The block sits between requester masters and the shared resource's mux select.

---
 rtl/lru_burst_sched_if.sv | 24 ++
 rtl/lru_burst_sched.sv | 112 +++++++++++
 2 files changed

// File: rtl/lru_burst_sched_if.sv
// Handshake bundle between requester masters and the burst scheduler.
// The master side drives request/last/enable; the slave side returns the grant.
interface lru_burst_sched_if #(
    parameter int REQ_NUM = 11,
    parameter int IDW     = $clog2(REQ_NUM)
);
    logic               arb_en;
    logic [REQ_NUM-1:0] req;
    logic [REQ_NUM-1:0] last;
    logic [REQ_NUM-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic               busy;
    logic               timeout;

    modport master (
        output arb_en, req, last,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  arb_en, req, last,
        output grant, grant_id, busy, timeout
    );
endinterface

// File: rtl/lru_burst_sched.sv
// Least-recently-granted burst scheduler: the winner holds the grant until last,
// request withdrawal or the MAX_HOLD limit, then one turnaround cycle follows.
module lru_burst_sched #(
    parameter int REQ_NUM  = 11,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(REQ_NUM),
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    lru_burst_sched_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [IDW-1:0]     r_prio [REQ_NUM];

    logic               w_found;
    logic [IDW-1:0]     w_win_id;
    logic [REQ_NUM-1:0] w_shift;
    logic               w_at_limit;
    logic               w_hold_req;
    logic               w_hold_last;
    logic               w_rel;

    // Walk the list from highest priority; w_shift marks the winner's slot and
    // everything below it, i.e. the entries that move up by one on a grant.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_shift  = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (!w_found && bus.req[r_prio[k]]) begin
                w_found  = 1'b1;
                w_win_id = r_prio[k];
            end
            w_shift[k] = w_found;
        end
    end

    assign w_at_limit  = (r_hold_cnt == CNT_W'(MAX_HOLD));
    assign w_hold_req  = bus.req[bus.grant_id];
    assign w_hold_last = bus.last[bus.grant_id];
    assign w_rel       = !w_hold_req || w_hold_last || w_at_limit;

    // NOTE: all state and outputs use non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            bus.grant    <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
            bus.timeout  <= 1'b0;
            // NOTE: the priority list is small register state that must restart at
            // identity order, so it is reset, unlike a datapath memory would be.
            for (int k = 0; k < REQ_NUM; k++) begin
                r_prio[k] <= IDW'(k);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    bus.timeout <= 1'b0;
                    if (bus.arb_en && w_found) begin
                        r_state      <= ST_GRANT;
                        r_hold_cnt   <= CNT_W'(1);
                        bus.grant    <= {{(REQ_NUM-1){1'b0}}, 1'b1} << w_win_id;
                        bus.grant_id <= w_win_id;
                        bus.busy     <= 1'b1;
                        for (int k = 0; k < REQ_NUM - 1; k++) begin
                            if (w_shift[k]) begin
                                r_prio[k] <= r_prio[k+1];
                            end
                        end
                        r_prio[REQ_NUM-1] <= w_win_id;
                    end
                end
                ST_GRANT: begin
                    if (w_rel) begin
                        r_state     <= ST_GAP;
                        bus.grant   <= '0;
                        bus.busy    <= 1'b0;
                        // Only a forced cut pulses timeout; a voluntary end on the
                        // limit cycle does not.
                        bus.timeout <= w_at_limit && w_hold_req && !w_hold_last;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    r_state     <= ST_IDLE;
                    bus.timeout <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    bus.grant   <= '0;
                    bus.busy    <= 1'b0;
                    bus.timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule
